// File: rtl/freq_meter_if.sv
// Control/result bundle of the gated frequency meter: start request in, measurement result out.
interface freq_meter_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             busy;
  logic [CNT_W-1:0] edge_cnt;
  logic             meas_valid;
  logic             overflow;
  logic             timeout;
  logic             in_range;

  modport master (
    output start,
    input  busy, edge_cnt, meas_valid, overflow, timeout, in_range
  );

  modport slave (
    input  start,
    output busy, edge_cnt, meas_valid, overflow, timeout, in_range
  );
endinterface

// File: rtl/freq_meter.sv
// Gated frequency meter: counts synchronized rising edges of sig_in over GATE_CYCLES clocks aligned to the first edge.
// Optional macro RANGE_CHECK_EN builds the CNT_LO..CNT_HI window comparator driving in_range.
module freq_meter #(
  parameter int GATE_CYCLES = 16384,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_LO      = 0,
  parameter int CNT_HI      = 65535
) (
  input  logic          clk_16_384m,
  input  logic          rst_n,
  input  logic          sig_in,
  freq_meter_if.slave   bus
);

  localparam int              GC_W    = $clog2(GATE_CYCLES + 1);
  localparam logic [GC_W-1:0] GC_LAST = GC_W'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    GATE = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_d_r;
  logic                   rise_s;
  logic [CNT_W-1:0]       acc_r;
  logic [CNT_W-1:0]       acc_nxt_s;
  logic [GC_W-1:0]        gcnt_r;
  logic [GC_W-1:0]        gcnt_nxt_s;
  logic                   ovf_r;
  logic                   ovf_nxt_s;
  logic                   tmo_r;
  logic                   tmo_nxt_s;
  logic                   busy_r;
  logic                   valid_r;
  logic [CNT_W-1:0]       edge_cnt_r;
  logic                   ovf_out_r;
  logic                   tmo_out_r;

  // Input synchronizer plus one delay flop for rising-edge detection
  always_ff @(posedge clk_16_384m or negedge rst_n) begin
    if (!rst_n) begin
      sync_r   <= {SYNC_STAGES{1'b0}};
      sync_d_r <= 1'b0;
    end else begin
      sync_r   <= {sync_r[SYNC_STAGES-2:0], sig_in};
      sync_d_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign rise_s = sync_r[SYNC_STAGES-1] & ~sync_d_r;

  // FSM state and measurement working registers
  always_ff @(posedge clk_16_384m or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      acc_r   <= {CNT_W{1'b0}};
      gcnt_r  <= {GC_W{1'b0}};
      ovf_r   <= 1'b0;
      tmo_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      acc_r   <= acc_nxt_s;
      gcnt_r  <= gcnt_nxt_s;
      ovf_r   <= ovf_nxt_s;
      tmo_r   <= tmo_nxt_s;
    end
  end

  // Next-state logic; the gate counter doubles as the ARM timeout counter
  always_comb begin
    state_nxt_s = state_r;
    acc_nxt_s   = acc_r;
    gcnt_nxt_s  = gcnt_r;
    ovf_nxt_s   = ovf_r;
    tmo_nxt_s   = tmo_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_nxt_s = ARM;
          acc_nxt_s   = {CNT_W{1'b0}};
          gcnt_nxt_s  = {GC_W{1'b0}};
          ovf_nxt_s   = 1'b0;
          tmo_nxt_s   = 1'b0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ARM: begin
        if (rise_s) begin
          state_nxt_s = GATE;
          gcnt_nxt_s  = {GC_W{1'b0}};
        end else if (gcnt_r == GC_LAST) begin
          state_nxt_s = DONE;
          acc_nxt_s   = {CNT_W{1'b0}};
          tmo_nxt_s   = 1'b1;
        end else begin
          gcnt_nxt_s  = gcnt_r + GC_W'(1);
        end
      end
      GATE: begin
        gcnt_nxt_s = gcnt_r + GC_W'(1);
        // A rise that would wrap the accumulator is dropped and flagged instead
        if (rise_s && (&acc_r)) begin
          ovf_nxt_s = 1'b1;
        end else if (rise_s) begin
          acc_nxt_s = acc_r + CNT_W'(1);
        end else begin
          acc_nxt_s = acc_r;
        end
        if (gcnt_r == GC_LAST) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = GATE;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Result registers load on entry to DONE so they change together with meas_valid
  always_ff @(posedge clk_16_384m or negedge rst_n) begin
    if (!rst_n) begin
      busy_r     <= 1'b0;
      valid_r    <= 1'b0;
      edge_cnt_r <= {CNT_W{1'b0}};
      ovf_out_r  <= 1'b0;
      tmo_out_r  <= 1'b0;
    end else begin
      busy_r  <= (state_nxt_s == ARM) || (state_nxt_s == GATE);
      valid_r <= (state_nxt_s == DONE);
      if (state_nxt_s == DONE) begin
        edge_cnt_r <= acc_nxt_s;
        ovf_out_r  <= ovf_nxt_s;
        tmo_out_r  <= tmo_nxt_s;
      end
    end
  end

`ifdef RANGE_CHECK_EN
  logic in_range_r;

  // Window comparator, qualified by a clean (non-saturated, non-timed-out) result
  always_ff @(posedge clk_16_384m or negedge rst_n) begin
    if (!rst_n) begin
      in_range_r <= 1'b0;
    end else if (state_nxt_s == DONE) begin
      in_range_r <= (int'(acc_nxt_s) >= CNT_LO) && (int'(acc_nxt_s) <= CNT_HI) &&
                    !ovf_nxt_s && !tmo_nxt_s;
    end
  end

  assign bus.in_range = in_range_r;
`else
  logic unused_range_s;
  assign unused_range_s = (CNT_LO > CNT_HI);
  assign bus.in_range   = 1'b0;
`endif

  assign bus.busy       = busy_r;
  assign bus.meas_valid = valid_r;
  assign bus.edge_cnt   = edge_cnt_r;
  assign bus.overflow   = ovf_out_r;
  assign bus.timeout    = tmo_out_r;

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: an event-time model predicts every output each cycle, plus hand-computed literal checks.
module tb_freq_meter;
  localparam int G    = 100;
  localparam int S    = 2;
  localparam int MAXC = 8192;
`ifdef RANGE_CHECK_EN
  localparam int RNG = 1;
`else
  localparam int RNG = 0;
`endif

  logic clk_16_384m = 1'b0;
  logic rst_n = 1'b0;
  logic sig_a = 1'b0;
  logic sig_b = 1'b0;
  int   period_a = 0;
  int   period_b = 0;

  freq_meter_if #(.CNT_W(16)) bus_a ();
  freq_meter_if #(.CNT_W(4))  bus_b ();

  freq_meter #(.GATE_CYCLES(G), .CNT_W(16), .SYNC_STAGES(S), .CNT_LO(9), .CNT_HI(11)) dut_a (
    .clk_16_384m(clk_16_384m), .rst_n(rst_n), .sig_in(sig_a), .bus(bus_a));
  freq_meter #(.GATE_CYCLES(G), .CNT_W(4), .SYNC_STAGES(S), .CNT_LO(0), .CNT_HI(15)) dut_b (
    .clk_16_384m(clk_16_384m), .rst_n(rst_n), .sig_in(sig_b), .bus(bus_b));

  initial forever #5 clk_16_384m = ~clk_16_384m;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- model: works on sample timestamps and gate windows ----------------
  bit samp [2][MAXC];
  bit m_act [2];
  int m_t [2], m_p [2], m_done [2], m_free [2];
  int e_cnt [2];
  bit e_ovf [2], e_tmo [2], e_rng [2], e_valid [2], e_busy [2];
  int cmax [2] = '{65535, 15};
  int lo [2]   = '{9, 0};
  int hi [2]   = '{11, 15};
  int vcount [2] = '{0, 0};

  // An input rise sampled at cycle k becomes visible to the meter at cycle k+S
  function automatic bit det(input int d, input int n);
    bit cur, prev;
    cur  = (n - S >= 0)     ? samp[d][n-S]   : 1'b0;
    prev = (n - S - 1 >= 0) ? samp[d][n-S-1] : 1'b0;
    return cur && !prev;
  endfunction

  function automatic int window_edges(input int d, input int p);
    int c = 0;
    for (int k = p + 1; k <= p + G; k++) if (det(d, k)) c++;
    return c;
  endfunction

  task automatic model_step(input int d, input int n, input bit rst_v, input bit start_v, input bit sig_v);
    int raw;
    samp[d][n] = rst_v && sig_v;
    e_valid[d] = 1'b0;
    if (!rst_v) begin
      m_act[d] = 1'b0; m_free[d] = 0; e_cnt[d] = 0;
      e_ovf[d] = 1'b0; e_tmo[d] = 1'b0; e_rng[d] = 1'b0;
    end else if (m_act[d]) begin
      if (m_p[d] < 0 && m_done[d] < 0) begin
        if (det(d, n)) begin
          m_p[d] = n; m_done[d] = n + G;
        end else if (n == m_t[d] + G) begin
          m_done[d] = n;
        end
      end
      if (n == m_done[d]) begin
        raw      = (m_p[d] < 0) ? 0 : window_edges(d, m_p[d]);
        e_tmo[d] = (m_p[d] < 0);
        e_ovf[d] = (raw > cmax[d]);
        e_cnt[d] = e_ovf[d] ? cmax[d] : raw;
        e_rng[d] = (RNG != 0) && e_cnt[d] >= lo[d] && e_cnt[d] <= hi[d] && !e_ovf[d] && !e_tmo[d];
        e_valid[d] = 1'b1;
        m_act[d]   = 1'b0;
        m_free[d]  = n + 2;
      end
    end else if (start_v && n >= m_free[d]) begin
      m_act[d] = 1'b1; m_t[d] = n; m_p[d] = -1; m_done[d] = -1;
    end
    e_busy[d] = m_act[d];
  endtask

  // Compare process: one model step and full output comparison per clock
  initial begin
    forever begin
      @(posedge clk_16_384m);
      #1;
      if (cyc >= MAXC) begin
        $display("FAIL cycle_budget: got %0d, expected below %0d", cyc, MAXC);
        $fatal(1);
      end
      model_step(0, cyc, rst_n, bus_a.start, sig_a);
      model_step(1, cyc, rst_n, bus_b.start, sig_b);
      check("a.valid",    int'(bus_a.meas_valid), int'(e_valid[0]));
      check("a.busy",     int'(bus_a.busy),       int'(e_busy[0]));
      check("a.edge_cnt", int'(bus_a.edge_cnt),   e_cnt[0]);
      check("a.overflow", int'(bus_a.overflow),   int'(e_ovf[0]));
      check("a.timeout",  int'(bus_a.timeout),    int'(e_tmo[0]));
      check("a.in_range", int'(bus_a.in_range),   int'(e_rng[0]));
      check("b.valid",    int'(bus_b.meas_valid), int'(e_valid[1]));
      check("b.busy",     int'(bus_b.busy),       int'(e_busy[1]));
      check("b.edge_cnt", int'(bus_b.edge_cnt),   e_cnt[1]);
      check("b.overflow", int'(bus_b.overflow),   int'(e_ovf[1]));
      check("b.timeout",  int'(bus_b.timeout),    int'(e_tmo[1]));
      check("b.in_range", int'(bus_b.in_range),   int'(e_rng[1]));
      vcount[0] += int'(bus_a.meas_valid);
      vcount[1] += int'(bus_b.meas_valid);
      cyc++;
    end
  end

  // Periodic input generators; a period of 0 holds the input low
  initial begin
    int pa = 0;
    int pb = 0;
    forever begin
      @(negedge clk_16_384m);
      if (period_a == 0) begin sig_a = 1'b0; pa = 0; end
      else begin pa = (pa + 1) % period_a; sig_a = (pa < period_a / 2); end
      if (period_b == 0) begin sig_b = 1'b0; pb = 0; end
      else begin pb = (pb + 1) % period_b; sig_b = (pb < period_b / 2); end
    end
  end

  task automatic pulse_start(input int d);
    @(negedge clk_16_384m);
    if (d == 0) bus_a.start = 1'b1; else bus_b.start = 1'b1;
    @(negedge clk_16_384m);
    if (d == 0) bus_a.start = 1'b0; else bus_b.start = 1'b0;
  endtask

  task automatic wait_valid(input int d, input int budget, output int waited);
    waited = -1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk_16_384m);
      if ((d == 0) ? bus_a.meas_valid : bus_b.meas_valid) begin
        waited = k;
        break;
      end
    end
    check((d == 0) ? "a.valid_in_time" : "b.valid_in_time", int'(waited > 0), 1);
  endtask

  initial begin
    int w;
    int vbase;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    period_a = 3;
    period_b = 3;
    repeat (5) @(negedge clk_16_384m);
    check("rst.a_edge_cnt", int'(bus_a.edge_cnt), 0);
    check("rst.a_busy",     int'(bus_a.busy), 0);
    rst_n = 1'b1;

    // 1: no start, input toggling, no result
    repeat (200) @(negedge clk_16_384m);
    check("t1.no_valid", vcount[0] + vcount[1], 0);

    // 2: period 10 -> 10 edges
    period_a = 10;
    repeat (20) @(negedge clk_16_384m);
    pulse_start(0);
    check("t2.busy_rise", int'(bus_a.busy), 1);
    wait_valid(0, 400, w);
    check("t2.edge_cnt", int'(bus_a.edge_cnt), 10);
    check("t2.overflow", int'(bus_a.overflow), 0);
    check("t2.timeout",  int'(bus_a.timeout), 0);
    check("t2.busy_low", int'(bus_a.busy), 0);
    check("t2.in_range", int'(bus_a.in_range), RNG);
    repeat (5) @(negedge clk_16_384m);
    check("t2.one_valid", vcount[0], 1);

    // 3: silent input -> timeout after exactly G ARM cycles, then period 4 -> 25
    period_a = 0;
    repeat (20) @(negedge clk_16_384m);
    pulse_start(0);
    wait_valid(0, 400, w);
    check("t3.tmo_latency", w, G);
    check("t3.edge_cnt", int'(bus_a.edge_cnt), 0);
    check("t3.timeout",  int'(bus_a.timeout), 1);
    check("t3.in_range", int'(bus_a.in_range), 0);
    period_a = 4;
    repeat (20) @(negedge clk_16_384m);
    pulse_start(0);
    wait_valid(0, 400, w);
    check("t3.edge_cnt2", int'(bus_a.edge_cnt), 25);
    check("t3.timeout2",  int'(bus_a.timeout), 0);

    // 4: 4-bit counter saturates
    period_b = 4;
    repeat (20) @(negedge clk_16_384m);
    pulse_start(1);
    wait_valid(1, 400, w);
    check("t4.edge_cnt", int'(bus_b.edge_cnt), 15);
    check("t4.overflow", int'(bus_b.overflow), 1);
    check("t4.in_range", int'(bus_b.in_range), 0);

    // 5: extra starts ignored, then reset mid-measurement
    period_a = 10;
    repeat (20) @(negedge clk_16_384m);
    vbase = vcount[0];
    pulse_start(0);
    repeat (30) @(negedge clk_16_384m);
    for (int i = 0; i < 3; i++) begin
      pulse_start(0);
      repeat (8) @(negedge clk_16_384m);
    end
    wait_valid(0, 400, w);
    check("t5.edge_cnt", int'(bus_a.edge_cnt), 10);
    repeat (150) @(negedge clk_16_384m);
    check("t5.one_valid", vcount[0] - vbase, 1);
    pulse_start(0);
    repeat (40) @(negedge clk_16_384m);
    rst_n = 1'b0;
    @(negedge clk_16_384m);
    check("t5.rst_busy",     int'(bus_a.busy), 0);
    check("t5.rst_edge_cnt", int'(bus_a.edge_cnt), 0);
    repeat (2) @(negedge clk_16_384m);
    rst_n = 1'b1;
    vbase = vcount[0];
    repeat (150) @(negedge clk_16_384m);
    check("t5.no_valid_after_rst", vcount[0] - vbase, 0);
    pulse_start(0);
    wait_valid(0, 400, w);
    check("t5.edge_cnt_after_rst", int'(bus_a.edge_cnt), 10);

    // 6: period 5 -> 20 edges, outside 9..11
    period_a = 5;
    repeat (20) @(negedge clk_16_384m);
    pulse_start(0);
    wait_valid(0, 400, w);
    check("t6.edge_cnt", int'(bus_a.edge_cnt), 20);
    check("t6.in_range", int'(bus_a.in_range), 0);

    repeat (5) @(negedge clk_16_384m);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
